mod_down_counter_load: RTL
==========================

MOD_DOWN_COUNTER_LOAD -- requirements
Module: mod_down_counter_load

Interface
REQ-001 Parameter: FINAL_VALUE, default 9, reload value and largest count, inclusive.
REQ-002 Localparam: BITS = $clog2(FINAL_VALUE+1); it SHALL hold FINAL_VALUE exactly (for example, 4 when FINAL_VALUE=9).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level; moves the FSM from IDLE to RUN.
REQ-006 enable  input  1  count strobe; decrements only in RUN.
REQ-007 load  input  1  synchronous parallel load.
REQ-008 load_value  input  BITS  value applied on load.
REQ-009 Q  output  BITS  current count, driven from a register.
REQ-010 zero  output  1  combinational, asserted when Q==0.
REQ-011 borrow  output  1  registered one-cycle terminal-count pulse, usable as the enable of a cascaded stage.
REQ-012 busy  output  1  registered, high while the FSM is in RUN.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and EXPIRED.
REQ-014 IDLE -> RUN on start=1; RUN and EXPIRED SHALL ignore start.
REQ-015 In RUN with enable=1 and Q>0, Q SHALL become Q-1 at the next edge.
REQ-016 In RUN with enable=1 and Q==0, borrow SHALL be 1 for exactly the next cycle, and Q SHALL follow REQ-029 or REQ-030.
REQ-017 With enable=0, or in IDLE or EXPIRED, Q SHALL hold and borrow SHALL be 0.
REQ-018 load SHALL take priority over enable in every state: Q <= min(load_value, FINAL_VALUE) at the next edge.
REQ-019 A load SHALL NOT generate borrow, even when Q==0 and enable=1 in the same cycle.
REQ-020 load in EXPIRED SHALL move the FSM to RUN; load in IDLE SHALL leave the FSM in IDLE.
REQ-021 All arithmetic SHALL be BITS wide and SHALL never produce a value greater than FINAL_VALUE or wrap to all-ones.
REQ-022 Latency SHALL be one cycle from load or enable to Q, and one cycle from the terminal decrement to borrow.

Reset
REQ-023 reset_n=0 SHALL immediately force: state=IDLE, Q=FINAL_VALUE, borrow=0, busy=0.
REQ-024 zero SHALL read 0 during reset, provided FINAL_VALUE>0.
REQ-025 Reset asserted mid-count SHALL abort the count with no borrow pulse; after release the FSM SHALL stay in IDLE until start.
REQ-026 Release of reset SHALL be safe at any time; the first edge after release SHALL see reset values.

Configuration
REQ-027 Macro MOD_DOWN_COUNTER_ONESHOT_EN SHALL select the behaviour after the terminal decrement.
REQ-028 The port list SHALL be identical with and without the macro.
REQ-029 Defined (one-shot): from Q==0 with enable=1, Q SHALL hold 0, the FSM SHALL go to EXPIRED and busy SHALL fall; only load (to RUN) or reset (to IDLE) SHALL leave EXPIRED.
REQ-030 Undefined (auto-reload): from Q==0 with enable=1, Q SHALL become FINAL_VALUE, the FSM SHALL stay in RUN, and EXPIRED SHALL be unreachable.

Verification (FINAL_VALUE=9, BITS=4)
REQ-031 Reset, then start=1 and enable held high -> Q: 9,8,...,0; borrow is high in the single cycle after Q==0; then Q=9 without the macro, or Q holds 0 with busy=0 with the macro.
REQ-032 load=1 with load_value=13 -> Q=9 next cycle; load_value=4 -> Q=4, with the state unchanged.
REQ-033 Q==0 with load=1, load_value=6 and enable=1 together -> Q=6 and borrow=0.
REQ-034 enable toggled 1,0,1 from Q=5 -> Q: 4,4,3; start ignored while in RUN.
REQ-035 reset_n pulsed low asynchronously (between edges) at Q=3 -> Q=9, busy=0 and borrow=0 immediately; enable is then ignored until start.
REQ-036 Macro defined, in EXPIRED, load_value=2 -> Q=2, busy=1, and counting resumes on enable.

Source files
------------

// File: rtl/mod_down_counter_load.sv
// rtl/mod_down_counter_load.sv - loadable modulo down-counter with IDLE/RUN/EXPIRED control FSM
// Define MOD_DOWN_COUNTER_ONESHOT_EN to stop in EXPIRED after the terminal count instead of reloading.
module mod_down_counter_load #(
  parameter  int FINAL_VALUE = 9,
  localparam int BITS        = $clog2(FINAL_VALUE + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            enable,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  output logic [BITS-1:0] Q,
  output logic            zero,
  output logic            borrow,
  output logic            busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_EXPIRED = 2'd2;

  localparam logic [BITS-1:0] L_FINAL = BITS'(FINAL_VALUE);
  localparam logic [BITS-1:0] L_ONE   = BITS'(1);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [BITS-1:0] r_q;
  logic [BITS-1:0] w_q_nxt;
  logic [BITS-1:0] w_load_sat;
  logic            r_borrow;
  logic            r_busy;
  logic            w_terminal;

  // Out-of-range load values clamp so Q never exceeds the modulus.
  assign w_load_sat = (load_value > L_FINAL) ? L_FINAL : load_value;

  // A load in the same cycle wins and suppresses the terminal-count pulse.
  assign w_terminal = (r_state == S_RUN) && enable && !load && (r_q == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;

    if (load) begin
      w_q_nxt = w_load_sat;
    end else if ((r_state == S_RUN) && enable) begin
      if (r_q != '0) begin
        w_q_nxt = r_q - L_ONE;
      end else begin
`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
        w_q_nxt = '0;
`else
        w_q_nxt = L_FINAL;
`endif
      end
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
        if (w_terminal) begin
          w_state_nxt = S_EXPIRED;
        end
`else
        w_state_nxt = S_RUN;
`endif
      end
      S_EXPIRED: begin
        if (load) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_q      <= L_FINAL;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_borrow <= w_terminal;
      r_busy   <= (w_state_nxt == S_RUN);
    end
  end

  assign Q      = r_q;
  assign zero   = (r_q == '0);
  assign borrow = r_borrow;
  assign busy   = r_busy;

endmodule
